alu_flags: RTL and testbench
============================

# alu_flags

Arithmetic datapath stage of the 8-bit CPU. Holds the A and B registers, the add/subtract unit and the flags register. Consumes the A/B/ALU/flags control strobes produced by the microcode control unit. Produces the carry and zero flags that feed back into the control unit's microcode address (cf, zf).

## Interface
Parameters:
- WIDTH, 8, datapath width in bits; the flag rules below apply for any WIDTH ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- clr_n  input  1  asynchronous, active-low reset.
- bus_in  input  WIDTH  value currently driven on the shared bus by the top-level mux.
- ai_bar  input  1  active-low: load A from bus_in.
- bi_bar  input  1  active-low: load B from bus_in.
- ao_bar  input  1  active-low: drive A onto bus_out.
- eo_bar  input  1  active-low: drive ALU result onto bus_out.
- su  input  1  active-high: ALU subtracts (A − B); else adds (A + B).
- fi_bar  input  1  active-low: latch carry/zero into the flags register.
- bus_out  output  WIDTH  A or ALU result; 0 when not driving.
- bus_oe  output  1  high when this block drives bus_out.
- cf  output  1  registered carry flag.
- zf  output  1  registered zero flag.
- bus_conflict  output  1  high in any cycle where ao_bar and eo_bar are both low.
- a_val  output  WIDTH  A register, for debug/display.
- b_val  output  WIDTH  B register, for debug/display.

## Operation
- Registers:
  - A, B: WIDTH bits each.
  - Flags: cf, zf.
  - Conflict-count register: 2-bit saturating count of conflict cycles, exposed only through bus_conflict sticky behaviour (below).
- Reset (clr_n low, asynchronous):
  - A = 0, B = 0, cf = 0, zf = 0, sticky conflict = 0.
  - Combinationally at reset: bus_out = 0, bus_oe = 0.
- ALU (combinational, WIDTH+1-bit result):
  - su = 0: {c, r} = A + B.
  - su = 1: {c, r} = A + ~B + 1.
  - Carry c means "no borrow" on subtract (A ≥ B unsigned). Overflow beyond WIDTH+1 bits is discarded.
  - z = (r == 0).
- Loads on rising clk:
  - ai_bar low: A ← bus_in.
  - bi_bar low: B ← bus_in.
  - fi_bar low: {cf, zf} ← {c, z}, computed from pre-edge A, B and su.
  - Strobes not asserted leave their register unchanged.
- Output mux:
  - ao_bar low: bus_out = A, bus_oe = 1.
  - Else eo_bar low: bus_out = r, bus_oe = 1.
  - Else bus_out = 0, bus_oe = 0.
- Simultaneous events:
  - ai_bar and bi_bar both low: both load the same bus_in.
  - ai_bar and fi_bar low together: flags reflect the old A.
  - eo_bar low with ai_bar low (A ← A±B through the bus): A loads whatever bus_in presents; this block does not loop back internally.
  - ao_bar and eo_bar both low: A wins on bus_out.
- bus_conflict:
  - Combinational on ao_bar & eo_bar.
  - ORed with a sticky bit that is set on any rising edge with a conflict present.
  - The sticky bit clears only on reset.
- Wrap-around:
  - 0xFF + 0x01 → r = 0x00, c = 1, z = 1.
  - 0x00 − 0x01 → r = 0xFF, c = 0, z = 0.

## Timing
- The control unit changes strobes on the falling clk edge. All strobes and bus_in are stable at the rising edge.
- Register loads: 1-cycle latency. New A/B are visible on a_val/b_val and bus_out immediately after the edge.
- ALU result and bus_out: zero-cycle combinational paths from A, B, su and the output enables.
- cf/zf: updated only at a rising edge with fi_bar low. They hold across any number of cycles otherwise, and do not track r.
- Reset mid-operation:
  - Asserting clr_n low clears state immediately, regardless of clk.
  - Deasserting it: the first rising edge with clr_n high performs normal loads.

## Test plan
- Reset: assert clr_n low mid-cycle with A=0x5A, cf=1 → a_val=0, b_val=0, cf=0, zf=0, bus_oe=0 before next clk edge.
- Add: load A=0x1C, B=0x0E, su=0, eo_bar low, fi_bar low for one edge → bus_out=0x2A, bus_oe=1, after edge cf=0, zf=0.
- Subtract/borrow: A=0x05, B=0x07, su=1 → bus_out=0xFE, latched cf=0, zf=0; then A=0x07, B=0x07 → bus_out=0x00, cf=1, zf=1.
- Carry wrap: A=0xFF, B=0x01, su=0, fi_bar low → cf=1, zf=1; next 3 cycles fi_bar high with A changed to 0x10 → cf, zf remain 1.
- Same-edge ai+fi: A=0x03, B=0x03, su=1, bus_in=0x09, ai_bar and fi_bar low → zf=1 (old A), a_val=0x09 after edge.
- Conflict: ao_bar and eo_bar low with A=0x11, B=0x01 → bus_out=0x11, bus_conflict=1; after one edge and release of both → bus_conflict stays 1 until clr_n pulse.

Source files
------------

// File: rtl/alu_flags.sv
// alu_flags: arithmetic stage of the 8-bit CPU.
// Holds the A/B registers, the add/subtract unit and the carry/zero flags,
// drives A or the ALU result onto the shared bus, and flags bus contention.
module alu_flags #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic [WIDTH-1:0] bus_in,
   input  logic             ai_bar,
   input  logic             bi_bar,
   input  logic             ao_bar,
   input  logic             eo_bar,
   input  logic             su,
   input  logic             fi_bar,
   output logic [WIDTH-1:0] bus_out,
   output logic             bus_oe,
   output logic             cf,
   output logic             zf,
   output logic             bus_conflict,
   output logic [WIDTH-1:0] a_val,
   output logic [WIDTH-1:0] b_val
);

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             cf_reg;
   logic             zf_reg;
   logic [1:0]       conflict_cnt;

   logic [WIDTH:0]   alu_sum;
   logic [WIDTH-1:0] alu_r;
   logic             alu_c;
   logic             alu_z;
   logic             conflict_now;
   logic             conflict_sticky;

   // Add/subtract: subtract is A + ~B + 1, so carry out means "no borrow".
   always_comb begin
      alu_sum = {1'b0, a_reg}
              + {1'b0, (su ? ~b_reg : b_reg)}
              + {{WIDTH{1'b0}}, su};
      alu_r   = alu_sum[WIDTH-1:0];
      alu_c   = alu_sum[WIDTH];
      alu_z   = (alu_r == '0);
   end

   // A and B operand registers, loaded from the shared bus.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         a_reg <= '0;
         b_reg <= '0;
      end else begin
         if (!ai_bar) a_reg <= bus_in;
         if (!bi_bar) b_reg <= bus_in;
      end
   end

   // Flags capture the ALU state seen before the edge (old A even when A loads too).
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         cf_reg <= 1'b0;
         zf_reg <= 1'b0;
      end else if (!fi_bar) begin
         cf_reg <= alu_c;
         zf_reg <= alu_z;
      end
   end

   assign conflict_now    = ~ao_bar & ~eo_bar;
   assign conflict_sticky = (conflict_cnt != 2'd0);

   // Saturating count of contention cycles; any non-zero count latches bus_conflict.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         conflict_cnt <= 2'd0;
      end else if (conflict_now && (conflict_cnt != 2'd3)) begin
         conflict_cnt <= conflict_cnt + 2'd1;
      end
   end

   // Bus driver: A has priority over the ALU result; silent while in reset.
   always_comb begin
      bus_out = '0;
      bus_oe  = 1'b0;
      if (clr_n) begin
         if (!ao_bar) begin
            bus_out = a_reg;
            bus_oe  = 1'b1;
         end else if (!eo_bar) begin
            bus_out = alu_r;
            bus_oe  = 1'b1;
         end
      end
   end

   assign bus_conflict = conflict_now | conflict_sticky;
   assign cf           = cf_reg;
   assign zf           = zf_reg;
   assign a_val        = a_reg;
   assign b_val        = b_reg;

endmodule

// File: tb/tb_alu_flags.sv
// Bench for alu_flags: expected values are queued when stimulus is applied
// and compared against the DUT when the corresponding output is sampled.
module tb_alu_flags;

   logic       clk;
   logic       clr_n;
   logic [7:0] bus_in;
   logic       ai_bar, bi_bar, ao_bar, eo_bar, su, fi_bar;
   logic [7:0] bus_out;
   logic       bus_oe, cf, zf, bus_conflict;
   logic [7:0] a_val, b_val;

   alu_flags #(.WIDTH(8)) dut (
      .clk(clk), .clr_n(clr_n), .bus_in(bus_in),
      .ai_bar(ai_bar), .bi_bar(bi_bar), .ao_bar(ao_bar), .eo_bar(eo_bar),
      .su(su), .fi_bar(fi_bar),
      .bus_out(bus_out), .bus_oe(bus_oe), .cf(cf), .zf(zf),
      .bus_conflict(bus_conflict), .a_val(a_val), .b_val(b_val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum {K_BUS, K_OE, K_CF, K_ZF, K_CONF, K_A, K_B} kind_t;
   typedef struct {
      kind_t      kind;
      string      tag;
      logic [7:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // reference model state
   logic [7:0] m_a, m_b;

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic push(input kind_t k, input string tag, input logic [7:0] e);
      exp_t x;
      x.kind = k;
      x.tag  = tag;
      x.exp  = e;
      sb.push_back(x);
   endtask

   task automatic drain();
      exp_t       x;
      logic [7:0] obs;
      while (sb.size() > 0) begin
         x = sb.pop_front();
         case (x.kind)
            K_BUS:   obs = bus_out;
            K_OE:    obs = {7'd0, bus_oe};
            K_CF:    obs = {7'd0, cf};
            K_ZF:    obs = {7'd0, zf};
            K_CONF:  obs = {7'd0, bus_conflict};
            K_A:     obs = a_val;
            default: obs = b_val;
         endcase
         check_val(x.tag, obs, x.exp);
      end
   endtask

   // Independent reference: plain integer arithmetic, unsigned compare for borrow.
   task automatic alu_ref(input logic [7:0] a, input logic [7:0] b, input logic s,
                          output logic [7:0] r, output logic c, output logic z);
      int ia, ib, t;
      ia = a;
      ib = b;
      if (s) begin
         t = ia - ib;
         c = (ia >= ib);
      end else begin
         t = ia + ib;
         c = (t > 255);
      end
      r = t[7:0];
      z = (r == 8'd0);
   endtask

   task automatic load_a(input logic [7:0] v);
      @(negedge clk);
      bus_in = v;
      ai_bar = 1'b0;
      @(posedge clk);
      #1;
      m_a = v;
      push(K_A, "load_a", v);
      drain();
      @(negedge clk);
      ai_bar = 1'b1;
   endtask

   task automatic load_b(input logic [7:0] v);
      @(negedge clk);
      bus_in = v;
      bi_bar = 1'b0;
      @(posedge clk);
      #1;
      m_b = v;
      push(K_B, "load_b", v);
      drain();
      @(negedge clk);
      bi_bar = 1'b1;
   endtask

   // Load operands, show the ALU result on the bus and latch flags.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input string tag);
      logic [7:0] r;
      logic       c, z;
      load_a(a);
      load_b(b);
      @(negedge clk);
      su     = s;
      eo_bar = 1'b0;
      fi_bar = 1'b0;
      alu_ref(m_a, m_b, s, r, c, z);
      push(K_BUS, {tag, "_bus"}, r);
      push(K_OE,  {tag, "_oe"}, 8'd1);
      #1;
      drain();
      @(posedge clk);
      #1;
      push(K_CF, {tag, "_cf"}, {7'd0, c});
      push(K_ZF, {tag, "_zf"}, {7'd0, z});
      drain();
      @(negedge clk);
      eo_bar = 1'b1;
      fi_bar = 1'b1;
      su     = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ra, rb;
      logic       rs;

      clr_n  = 1'b0;
      bus_in = 8'h00;
      ai_bar = 1'b1; bi_bar = 1'b1; ao_bar = 1'b1; eo_bar = 1'b1;
      fi_bar = 1'b1; su = 1'b0;
      m_a = 8'h00; m_b = 8'h00;
      #3;
      push(K_A, "rst_a", 8'h00);
      push(K_B, "rst_b", 8'h00);
      push(K_CF, "rst_cf", 8'h00);
      push(K_ZF, "rst_zf", 8'h00);
      push(K_OE, "rst_oe", 8'h00);
      push(K_CONF, "rst_conf", 8'h00);
      drain();
      @(negedge clk);
      clr_n = 1'b1;

      // mid-cycle asynchronous reset with A=0x5A, cf=1
      run_op(8'h5A, 8'hFF, 1'b0, "pre_rst");
      @(negedge clk);
      ao_bar = 1'b0;
      #2;
      clr_n = 1'b0;
      #1;
      push(K_A, "async_a", 8'h00);
      push(K_B, "async_b", 8'h00);
      push(K_CF, "async_cf", 8'h00);
      push(K_ZF, "async_zf", 8'h00);
      push(K_OE, "async_oe", 8'h00);
      push(K_BUS, "async_bus", 8'h00);
      drain();
      @(negedge clk);
      ao_bar = 1'b1;
      clr_n  = 1'b1;
      m_a = 8'h00; m_b = 8'h00;

      run_op(8'h1C, 8'h0E, 1'b0, "add");
      run_op(8'h05, 8'h07, 1'b1, "sub_borrow");
      run_op(8'h07, 8'h07, 1'b1, "sub_eq");
      run_op(8'hFF, 8'h01, 1'b0, "wrap_add");

      // flags hold while A changes and fi_bar stays high
      load_a(8'h10);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         push(K_CF, "hold_cf", 8'h01);
         push(K_ZF, "hold_zf", 8'h01);
         drain();
      end

      run_op(8'h00, 8'h01, 1'b1, "wrap_sub");

      // flags see old A when A loads on the same edge
      load_a(8'h03);
      load_b(8'h03);
      @(negedge clk);
      su     = 1'b1;
      bus_in = 8'h09;
      ai_bar = 1'b0;
      fi_bar = 1'b0;
      @(posedge clk);
      #1;
      m_a = 8'h09;
      push(K_ZF, "same_edge_zf", 8'h01);
      push(K_CF, "same_edge_cf", 8'h01);
      push(K_A,  "same_edge_a", 8'h09);
      drain();
      @(negedge clk);
      ai_bar = 1'b1; fi_bar = 1'b1; su = 1'b0;

      // A and B load the same bus value
      @(negedge clk);
      bus_in = 8'h33;
      ai_bar = 1'b0;
      bi_bar = 1'b0;
      @(posedge clk);
      #1;
      m_a = 8'h33; m_b = 8'h33;
      push(K_A, "dual_a", 8'h33);
      push(K_B, "dual_b", 8'h33);
      drain();
      @(negedge clk);
      ai_bar = 1'b1; bi_bar = 1'b1;

      // A loads the external bus while the ALU drives out; no internal loopback
      @(negedge clk);
      eo_bar = 1'b0;
      ai_bar = 1'b0;
      bus_in = 8'h77;
      @(posedge clk);
      #1;
      m_a = 8'h77;
      push(K_A, "eo_ai_a", 8'h77);
      push(K_BUS, "eo_ai_bus", 8'hAA);
      drain();
      @(negedge clk);
      eo_bar = 1'b1; ai_bar = 1'b1;

      // randomized add/sub against the reference
      for (int i = 0; i < 16; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rs = 1'($urandom_range(0, 1));
         run_op(ra, rb, rs, "rand");
      end

      // bus contention: A wins, conflict becomes sticky until reset
      load_a(8'h11);
      load_b(8'h01);
      @(negedge clk);
      push(K_CONF, "no_conf", 8'h00);
      drain();
      ao_bar = 1'b0;
      eo_bar = 1'b0;
      #1;
      push(K_BUS, "conf_bus", 8'h11);
      push(K_OE, "conf_oe", 8'h01);
      push(K_CONF, "conf_now", 8'h01);
      drain();
      @(posedge clk);
      @(negedge clk);
      ao_bar = 1'b1;
      eo_bar = 1'b1;
      #1;
      push(K_CONF, "conf_sticky", 8'h01);
      push(K_OE, "conf_idle_oe", 8'h00);
      push(K_BUS, "conf_idle_bus", 8'h00);
      drain();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         push(K_CONF, "conf_hold", 8'h01);
         drain();
      end
      @(negedge clk);
      clr_n = 1'b0;
      #1;
      push(K_CONF, "conf_clr", 8'h00);
      drain();
      @(negedge clk);
      clr_n = 1'b1;
      @(posedge clk);
      #1;
      push(K_CONF, "conf_after_clr", 8'h00);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
